button_direction_decoder: RTL and testbench
===========================================

# button_direction_decoder

Consumes the four debounced button levels from the debouncing block and turns them into direction commands for the Pac-Man movement logic. It detects presses, resolves simultaneous presses by fixed priority, and holds one pending command in a valid/ready output register until the game logic accepts it. An optional auto-repeat engine re-issues the held direction at a fixed rate.

## Interface

Parameters:
- HOLD_TICKS, 16: d_clk cycles a button must stay held before the first repeat.
- REPEAT_TICKS, 8: d_clk cycles between subsequent repeats.

Ports:
- d_clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- b3  in  1  debounced UP level, already synchronous to d_clk.
- b2  in  1  debounced DOWN level.
- b1  in  1  debounced LEFT level.
- b0  in  1  debounced RIGHT level.
- dir_ready  in  1  game logic accepts the pending command this cycle.
- dir_valid  out  1  a command is pending.
- dir  out  2  pending command: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT.
- cur_dir  out  2  last accepted direction, updated on each handshake.

## Operation

- Reset (rst low) clears all state: dir_valid=0, dir=00, cur_dir=00, previous-level register=0000, FSM=IDLE, counter=0.
- Press detection: register previous levels {b3,b2,b1,b0}. A press is b & ~prev.
- Priority on simultaneous presses: b3 > b2 > b1 > b0. Lower-priority presses in the same cycle are dropped.
- Output register holds one entry:
  - A press or repeat event loads dir and sets dir_valid.
  - A handshake (dir_valid & dir_ready) copies dir into cur_dir and clears dir_valid, unless a new event loads in the same cycle. In that case dir takes the new value and dir_valid stays 1.
  - A new event while the entry is pending and unaccepted overwrites dir (latest wins) and does not drop dir_valid.
- Hold FSM (only with auto-repeat enabled). The tracked button is the one that produced the last press event.
  - IDLE to DELAY on a press event; counter cleared.
  - In DELAY, the counter increments each cycle. At HOLD_TICKS-1, if the tracked button is still high: emit a repeat event, clear the counter, go to REPEAT.
  - In REPEAT, the counter runs the same way. At REPEAT_TICKS-1: emit a repeat event and clear the counter.
  - From DELAY or REPEAT: tracked button low returns to IDLE; a new press restarts DELAY with the new button.
  - A press and a repeat terminal count in the same cycle: the press wins and the repeat is suppressed.
- The counter width is sized for max(HOLD_TICKS, REPEAT_TICKS). The counter never wraps: it is cleared on every terminal count.

## Timing

- Press latency: b sampled high at edge k (prev low) gives dir_valid=1 and dir valid after edge k. dir_ready may be accepted at edge k+1.
- A handshake at edge j gives cur_dir updated and dir_valid=0 after edge j.
- First repeat: HOLD_TICKS cycles after the press edge. Subsequent repeats come every REPEAT_TICKS cycles.
- Asserting reset mid-operation immediately clears dir_valid and the FSM. A button still held at release of reset counts as a press on the first clock after release, because prev is 0.

## Configuration

- BTN_AUTOREPEAT_EN defined: the hold FSM and repeat counter are built, and both parameters are active.
- BTN_AUTOREPEAT_EN undefined: there is no FSM or counter. Only press events load the output register, and holding a button produces exactly one command.

## Structure

- Shared package pacman_input_pkg holds:
  - direction codes DIR_UP/DOWN/LEFT/RIGHT (2-bit);
  - hold FSM state encoding IDLE/DELAY/REPEAT.
- One sub-module, btn_repeat_timer, contains the FSM and counter and emits a one-cycle repeat pulse. It is instantiated only under BTN_AUTOREPEAT_EN.

## Test plan

- Reset with b2 held high; release reset -> dir_valid=1, dir=01 one cycle after the first edge; dir_ready=1 -> cur_dir=01, dir_valid=0.
- b3 and b0 rise in the same cycle -> single command dir=00; no RIGHT command ever appears.
- Press b1, hold dir_ready=0, then press b0 -> dir changes 10 to 11 while dir_valid stays 1 throughout.
- With enabled, HOLD_TICKS=16, REPEAT_TICKS=8, dir_ready tied 1, b1 held for 40 cycles -> events at press, +16, +24, +32, +40; release -> no further events.
- Handshake and new press in the same cycle -> cur_dir = old dir, dir = new code, dir_valid=1.
- Without the macro, b0 held 100 cycles with dir_ready=1 -> exactly one command, dir=11.

Source files
------------

// File: rtl/pacman_input_pkg.sv
// Shared definitions for the Pac-Man button input path:
// direction codes, hold FSM states and press priority helpers.
package pacman_input_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        REPEAT = 2'b10
    } hold_st_e;

    // Levels are packed {UP, DOWN, LEFT, RIGHT}; UP has highest priority.
    function automatic logic [1:0] prio_dir(input logic [3:0] i_vec);
        logic [1:0] w_d;
        w_d = DIR_UP;
        priority case (1'b1)
            i_vec[3]: w_d = DIR_UP;
            i_vec[2]: w_d = DIR_DOWN;
            i_vec[1]: w_d = DIR_LEFT;
            i_vec[0]: w_d = DIR_RIGHT;
            default:  w_d = DIR_UP;
        endcase
        return w_d;
    endfunction

    function automatic logic btn_level(
        input logic [3:0] i_lvl,
        input logic [1:0] i_dir
    );
        logic w_l;
        unique case (i_dir)
            DIR_UP:    w_l = i_lvl[3];
            DIR_DOWN:  w_l = i_lvl[2];
            DIR_LEFT:  w_l = i_lvl[1];
            DIR_RIGHT: w_l = i_lvl[0];
            default:   w_l = 1'b0;
        endcase
        return w_l;
    endfunction

endpackage

// File: rtl/btn_repeat_timer.sv
// Hold FSM and repeat counter: emits a one-cycle repeat pulse
// while the most recently pressed button stays held.
module btn_repeat_timer
    import pacman_input_pkg::*;
#(
    parameter int HOLD_TICKS   = 16,
    parameter int REPEAT_TICKS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_press,
    input  logic [1:0] i_press_dir,
    input  logic [3:0] i_levels,
    output logic       o_repeat,
    output logic [1:0] o_dir
);

    localparam int MAXT = (HOLD_TICKS > REPEAT_TICKS) ?
                          HOLD_TICKS : REPEAT_TICKS;
    localparam int CW = (MAXT > 2) ? $clog2(MAXT) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

    hold_st_e      r_state;
    hold_st_e      w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_trk;
    logic [1:0]    w_trk_nxt;
    logic          w_rep;
    logic          w_held;

    assign w_held = btn_level(i_levels, r_trk);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_trk   <= DIR_UP;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_trk   <= w_trk_nxt;
        end
    end

    // A fresh press always retargets the timer and masks any terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_trk_nxt   = r_trk;
        w_rep       = 1'b0;
        if (i_press) begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = '0;
            w_trk_nxt   = i_press_dir;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                end
                DELAY: begin
                    if (!w_held) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_rep       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!w_held) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == REP_LAST) begin
                        w_rep     = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_repeat = w_rep;
    assign o_dir    = r_trk;

endmodule

// File: rtl/button_direction_decoder.sv
// Turns debounced button levels into prioritised direction commands.
// Define BTN_AUTOREPEAT_EN to build the hold/auto-repeat engine.
module button_direction_decoder
    import pacman_input_pkg::*;
#(
    parameter int HOLD_TICKS   = 16,
    parameter int REPEAT_TICKS = 8
) (
    input  logic       d_clk,
    input  logic       rst,
    input  logic       b3,
    input  logic       b2,
    input  logic       b1,
    input  logic       b0,
    input  logic       dir_ready,
    output logic       dir_valid,
    output logic [1:0] dir,
    output logic [1:0] cur_dir
);

    if (HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("HOLD_TICKS and REPEAT_TICKS must be >= 1");
    end

    logic [3:0] w_levels;
    logic [3:0] r_prev;
    logic [3:0] w_press_vec;
    logic       w_press;
    logic [1:0] w_press_dir;
    logic       w_event;
    logic [1:0] w_ev_dir;
    logic       w_hs;
    logic       r_valid;
    logic [1:0] r_dir;
    logic [1:0] r_cur;

    assign w_levels    = {b3, b2, b1, b0};
    assign w_press_vec = w_levels & ~r_prev;
    assign w_press     = |w_press_vec;
    assign w_press_dir = prio_dir(w_press_vec);
    assign w_hs        = r_valid & dir_ready;

`ifdef BTN_AUTOREPEAT_EN
    logic       w_rep;
    logic [1:0] w_trk_dir;

    btn_repeat_timer #(
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_timer (
        .i_clk      (d_clk),
        .i_rst_n    (rst),
        .i_press    (w_press),
        .i_press_dir(w_press_dir),
        .i_levels   (w_levels),
        .o_repeat   (w_rep),
        .o_dir      (w_trk_dir)
    );

    assign w_event  = w_press | w_rep;
    assign w_ev_dir = w_press ? w_press_dir : w_trk_dir;
`else
    assign w_event  = w_press;
    assign w_ev_dir = w_press_dir;
`endif

    // A new event overrides the clear of a same-cycle handshake.
    always_ff @(posedge d_clk or negedge rst) begin
        if (!rst) begin
            r_prev  <= '0;
            r_valid <= 1'b0;
            r_dir   <= DIR_UP;
            r_cur   <= DIR_UP;
        end else begin
            r_prev <= w_levels;
            if (w_hs) begin
                r_cur <= r_dir;
            end
            if (w_event) begin
                r_valid <= 1'b1;
                r_dir   <= w_ev_dir;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dir_valid = r_valid;
    assign dir       = r_dir;
    assign cur_dir   = r_cur;

endmodule

// File: tb/tb_button_direction_decoder.sv
// Randomised and directed bench for button_direction_decoder
// against a cycle-level behavioural model.
module tb_button_direction_decoder;

    localparam int HT = 16;
    localparam int RT = 8;

    logic       d_clk = 1'b0;
    logic       rst = 1'b0;
    logic       dir_ready = 1'b0;
    logic [3:0] bv = 4'b0000;
    logic       dir_valid;
    logic [1:0] dir;
    logic [1:0] cur_dir;

    button_direction_decoder #(
        .HOLD_TICKS  (HT),
        .REPEAT_TICKS(RT)
    ) u_dut (
        .d_clk    (d_clk),
        .rst      (rst),
        .b3       (bv[3]),
        .b2       (bv[2]),
        .b1       (bv[1]),
        .b0       (bv[0]),
        .dir_ready(dir_ready),
        .dir_valid(dir_valid),
        .dir      (dir),
        .cur_dir  (cur_dir)
    );

    always #5 d_clk = ~d_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ev_cnt  = 0;

    logic [3:0] m_prev;
    logic       m_val;
    logic [1:0] m_dir;
    logic [1:0] m_cur;
    logic       m_trk_on;
    int         m_trk;
    int         m_age;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev   = 4'b0000;
        m_val    = 1'b0;
        m_dir    = 2'b00;
        m_cur    = 2'b00;
        m_trk_on = 1'b0;
        m_trk    = 0;
        m_age    = 0;
    endtask

    // Code of the highest-priority set bit (bit 3 = UP = code 0).
    function automatic int top_code(input logic [3:0] v);
        for (int i = 3; i >= 0; i--)
            if (v[i]) return 3 - i;
        return 0;
    endfunction

    // Repeats expected while a button is held across n sampling edges.
    function automatic int reps(input int n);
`ifdef BTN_AUTOREPEAT_EN
        return (n - 1 >= HT) ? 1 + (n - 1 - HT) / RT : 0;
`else
        return (n < 0) ? 1 : 0;
`endif
    endfunction

    task automatic model_step();
        logic [3:0] pv;
        logic       ev;
        int         ed;
        if (!rst) begin
            model_reset();
            return;
        end
        pv = bv & ~m_prev;
        ev = 1'b0;
        ed = 0;
        if (pv != 4'b0000) begin
            ev = 1'b1;
            ed = top_code(pv);
        end
`ifdef BTN_AUTOREPEAT_EN
        if (ev) begin
            m_trk_on = 1'b1;
            m_trk    = ed;
            m_age    = 0;
        end else if (m_trk_on) begin
            if (!bv[3 - m_trk]) begin
                m_trk_on = 1'b0;
            end else begin
                m_age++;
                if (m_age == HT ||
                    (m_age > HT && (m_age - HT) % RT == 0)) begin
                    ev = 1'b1;
                    ed = m_trk;
                end
            end
        end
`endif
        if (m_val && dir_ready) m_cur = m_dir;
        if (ev) begin
            m_val = 1'b1;
            m_dir = 2'(ed);
        end else if (m_val && dir_ready) begin
            m_val = 1'b0;
        end
        m_prev = bv;
    endtask

    task automatic cyc();
        @(posedge d_clk);
        model_step();
        #1;
        check("valid", 8'(dir_valid), 8'(m_val));
        check("dir", 8'(dir), 8'(m_dir));
        check("cur_dir", 8'(cur_dir), 8'(m_cur));
        if (dir_valid) ev_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        model_reset();
        bv  = 4'b0100;
        #2;
        check("rst_valid", 8'(dir_valid), 8'd0);
        check("rst_dir", 8'(dir), 8'd0);
        check("rst_cur", 8'(cur_dir), 8'd0);
        idle(2);
        rst = 1'b1;
        cyc();
        check("rel_valid", 8'(dir_valid), 8'd1);
        check("rel_dir", 8'(dir), 8'd1);
        dir_ready = 1'b1;
        cyc();
        check("rel_cur", 8'(cur_dir), 8'd1);
        check("rel_clr", 8'(dir_valid), 8'd0);

        bv = 4'b0000;
        idle(2);
        ev_cnt = 0;
        bv = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("no_right", 8'(dir_valid && dir == 2'b11), 8'd0);
        end
        check("prio_cnt", 8'(ev_cnt), 8'd1);
        check("prio_cur", 8'(cur_dir), 8'd0);

        bv = 4'b0000;
        idle(2);
        dir_ready = 1'b0;
        bv = 4'b0010;
        cyc();
        check("ow_dir0", 8'(dir), 8'd2);
        cyc();
        check("ow_val1", 8'(dir_valid), 8'd1);
        bv = 4'b0011;
        cyc();
        check("ow_dir1", 8'(dir), 8'd3);
        check("ow_val2", 8'(dir_valid), 8'd1);
        dir_ready = 1'b1;
        cyc();

        bv = 4'b0000;
        idle(3);
        ev_cnt = 0;
        bv = 4'b0010;
        idle(41);
        bv = 4'b0000;
        idle(20);
        check("hold40", 8'(ev_cnt), 8'(1 + reps(41)));

        dir_ready = 1'b0;
        idle(2);
        bv = 4'b0010;
        cyc();
        bv = 4'b0110;
        dir_ready = 1'b1;
        cyc();
        check("hs_cur", 8'(cur_dir), 8'd2);
        check("hs_dir", 8'(dir), 8'd1);
        check("hs_val", 8'(dir_valid), 8'd1);

        bv = 4'b0000;
        idle(3);
        ev_cnt = 0;
        bv = 4'b0001;
        idle(100);
        check("hold100_dir", 8'(dir), 8'd3);
        bv = 4'b0000;
        idle(5);
        check("hold100", 8'(ev_cnt), 8'(1 + reps(100)));

        dir_ready = 1'b0;
        bv = 4'b1000;
        idle(3);
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_val", 8'(dir_valid), 8'd0);
        check("mid_rst_cur", 8'(cur_dir), 8'd0);
        idle(2);
        rst = 1'b1;
        cyc();
        check("mid_rel_val", 8'(dir_valid), 8'd1);
        check("mid_rel_dir", 8'(dir), 8'd0);

        for (int i = 0; i < 2500; i++) begin
            int idx;
            if ($urandom % 6 == 0) begin
                idx = int'($urandom % 4);
                bv[idx] = ~bv[idx];
            end
            dir_ready = ($urandom % 3) != 0;
            if ($urandom % 600 == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                check("rnd_rst", 8'(dir_valid), 8'd0);
                cyc();
                rst = 1'b1;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
